// File: rtl/pipe_demux2.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_demux2
//  Description : 1-to-2 valid/ready demultiplexer. Each output port owns an
//                independent 2-entry skid FIFO; in_sel routes an accepted beat
//                to one of them. Saturating per-port transfer counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_demux2 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             in_pvld,
   output logic             in_prdy,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_pd,
   output logic             out0_pvld,
   input  logic             out0_prdy,
   output logic [WIDTH-1:0] out0_pd,
   output logic             out1_pvld,
   input  logic             out1_prdy,
   output logic [WIDTH-1:0] out1_pd,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] out0_cnt,
   output logic [CNT_W-1:0] out1_cnt
);

   // Occupancy of one 2-entry FIFO.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } occ_t;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [1:0]             w_sel_hit;
   logic [1:0]             w_not_full;
   logic [1:0]             w_pvld;
   logic [1:0]             w_prdy;
   logic [1:0]             w_push;
   logic [1:0]             w_pop;
   logic [1:0][WIDTH-1:0]  w_pd;
   logic [1:0][CNT_W-1:0]  w_cnt;
   logic                   w_accept;

   assign w_sel_hit[0] = ~in_sel;
   assign w_sel_hit[1] =  in_sel;
   assign w_prdy[0]    = out0_prdy;
   assign w_prdy[1]    = out1_prdy;

   // Ready comes only from registered occupancy of the selected FIFO, so a
   // same-cycle pop never raises it and there is no path from outN_prdy.
   assign in_prdy  = in_sel ? w_not_full[1] : w_not_full[0];
   assign w_accept = in_pvld & in_prdy;

   assign out0_pvld = w_pvld[0];
   assign out1_pvld = w_pvld[1];
   assign out0_pd   = w_pd[0];
   assign out1_pd   = w_pd[1];
   assign out0_cnt  = w_cnt[0];
   assign out1_cnt  = w_cnt[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      occ_t             r_state;
      occ_t             w_state_nxt;
      logic             r_wptr;
      logic             r_rptr;
      logic [WIDTH-1:0] r_mem [2];
      logic [CNT_W-1:0] r_cnt;

      assign w_push[gi]     = w_accept & w_sel_hit[gi];
      assign w_pop[gi]      = w_pvld[gi] & w_prdy[gi];
      assign w_pvld[gi]     = (r_state != EMPTY);
      assign w_not_full[gi] = (r_state != FULL);
      assign w_pd[gi]       = r_mem[r_rptr];
      assign w_cnt[gi]      = r_cnt;

      // Occupancy state and 1-bit pointers; reset empties the FIFO at once.
      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
         if (!nvdla_core_rstn) begin
            r_state <= EMPTY;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            if (w_push[gi]) r_wptr <= ~r_wptr;
            if (w_pop[gi])  r_rptr <= ~r_rptr;
         end
      end

      // Next occupancy: push-only grows, pop-only shrinks, both holds.
      always_comb begin
         w_state_nxt = r_state;
         case (r_state)
            EMPTY: begin
               if (w_push[gi]) w_state_nxt = HALF;
            end
            HALF: begin
               if (w_push[gi] && !w_pop[gi])      w_state_nxt = FULL;
               else if (w_pop[gi] && !w_push[gi]) w_state_nxt = EMPTY;
            end
            FULL: begin
               // Push cannot happen here since in_prdy is low for this port.
               if (w_pop[gi]) w_state_nxt = HALF;
            end
            default: w_state_nxt = EMPTY;
         endcase
      end

      // Payload storage; contents are only meaningful while occupied.
      always_ff @(posedge nvdla_core_clk) begin
         if (w_push[gi]) r_mem[r_wptr] <= in_pd;
      end

      // Saturating transfer counter; clear wins over a same-cycle increment.
      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
         if (!nvdla_core_rstn) begin
            r_cnt <= '0;
         end else if (cnt_clr) begin
            r_cnt <= '0;
         end else if (w_pop[gi] && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_demux2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_demux2
//  Description : Self-checking bench for pipe_demux2: directed vector table
//                plus throughput, saturation/clear and mid-run reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_demux2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_pvld;
   logic        in_sel;
   logic [31:0] in_pd;
   logic        out0_prdy;
   logic        out1_prdy;
   logic        cnt_clr;

   logic        in_prdy,   in_prdy4;
   logic        out0_pvld, out0_pvld4;
   logic        out1_pvld, out1_pvld4;
   logic [31:0] out0_pd,   out0_pd4;
   logic [31:0] out1_pd,   out1_pd4;
   logic [15:0] out0_cnt,  out1_cnt;
   logic [3:0]  out0_cnt4, out1_cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_demux2 #(.WIDTH(32), .CNT_W(16)) dut (
      .nvdla_core_clk (clk),       .nvdla_core_rstn (rst_n),
      .in_pvld        (in_pvld),   .in_prdy         (in_prdy),
      .in_sel         (in_sel),    .in_pd           (in_pd),
      .out0_pvld      (out0_pvld), .out0_prdy       (out0_prdy),
      .out0_pd        (out0_pd),
      .out1_pvld      (out1_pvld), .out1_prdy       (out1_prdy),
      .out1_pd        (out1_pd),
      .cnt_clr        (cnt_clr),
      .out0_cnt       (out0_cnt),  .out1_cnt        (out1_cnt)
   );

   pipe_demux2 #(.WIDTH(32), .CNT_W(4)) dut4 (
      .nvdla_core_clk (clk),        .nvdla_core_rstn (rst_n),
      .in_pvld        (in_pvld),    .in_prdy         (in_prdy4),
      .in_sel         (in_sel),     .in_pd           (in_pd),
      .out0_pvld      (out0_pvld4), .out0_prdy       (out0_prdy),
      .out0_pd        (out0_pd4),
      .out1_pvld      (out1_pvld4), .out1_prdy       (out1_prdy),
      .out1_pd        (out1_pd4),
      .cnt_clr        (cnt_clr),
      .out0_cnt       (out0_cnt4),  .out1_cnt        (out1_cnt4)
   );

   typedef struct {
      logic        pvld;
      logic        sel;
      logic [31:0] pd;
      logic        p0;
      logic        p1;
      logic        clr;
      logic        e_prdy;   // in_prdy before the edge
      logic        e_v0;     // state after the edge
      logic [31:0] e_d0;
      logic        e_v1;
      logic [31:0] e_d1;
      int          e_c0;
      int          e_c1;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic pv, input logic s, input logic [31:0] d,
                        input logic p0, input logic p1, input logic c);
      in_pvld   = pv;
      in_sel    = s;
      in_pd     = d;
      out0_prdy = p0;
      out1_prdy = p1;
      cnt_clr   = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // route A5/5A, then backpressure 1,2,3 with an independent sel=1 beat
      vecs[0]  = '{1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        0, 0};
      vecs[1]  = '{1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h5A5A5A5A, 1, 0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1, 1};
      vecs[3]  = '{1'b1, 1'b0, 32'h1,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1,        1'b0, 32'h0,        1, 1};
      vecs[4]  = '{1'b1, 1'b0, 32'h2,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1,        1'b0, 32'h0,        1, 1};
      vecs[5]  = '{1'b1, 1'b0, 32'h3,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,        1'b0, 32'h0,        1, 1};
      vecs[6]  = '{1'b1, 1'b1, 32'hC3,       1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,        1'b1, 32'hC3,       1, 1};
      vecs[7]  = '{1'b1, 1'b0, 32'h3,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 32'h0,        2, 2};
      vecs[8]  = '{1'b1, 1'b0, 32'h3,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3,        1'b0, 32'h0,        3, 2};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        4, 2};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        0, 0};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      #12;
      check("rst_in_prdy",    32'(in_prdy),   32'h1);
      check("rst_out0_pvld",  32'(out0_pvld), 32'h0);
      check("rst_out1_pvld",  32'(out1_pvld), 32'h0);
      check("rst_out0_cnt",   32'(out0_cnt),  32'h0);
      check("rst_out1_cnt",   32'(out1_cnt),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed vector table, applied to both instances.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].pvld, vecs[i].sel, vecs[i].pd, vecs[i].p0, vecs[i].p1, vecs[i].clr);
         #1;
         check($sformatf("v%0d_in_prdy", i),  32'(in_prdy),  32'(vecs[i].e_prdy));
         check($sformatf("v%0d_in_prdy4", i), 32'(in_prdy4), 32'(vecs[i].e_prdy));
         tick();
         check($sformatf("v%0d_out0_pvld", i),  32'(out0_pvld),  32'(vecs[i].e_v0));
         check($sformatf("v%0d_out1_pvld", i),  32'(out1_pvld),  32'(vecs[i].e_v1));
         check($sformatf("v%0d_out0_pvld4", i), 32'(out0_pvld4), 32'(vecs[i].e_v0));
         check($sformatf("v%0d_out1_pvld4", i), 32'(out1_pvld4), 32'(vecs[i].e_v1));
         if (vecs[i].e_v0) begin
            check($sformatf("v%0d_out0_pd", i),  out0_pd,  vecs[i].e_d0);
            check($sformatf("v%0d_out0_pd4", i), out0_pd4, vecs[i].e_d0);
         end
         if (vecs[i].e_v1) begin
            check($sformatf("v%0d_out1_pd", i),  out1_pd,  vecs[i].e_d1);
            check($sformatf("v%0d_out1_pd4", i), out1_pd4, vecs[i].e_d1);
         end
         check($sformatf("v%0d_out0_cnt", i),  32'(out0_cnt),  32'(vecs[i].e_c0));
         check($sformatf("v%0d_out1_cnt", i),  32'(out1_cnt),  32'(vecs[i].e_c1));
         check($sformatf("v%0d_out0_cnt4", i), 32'(out0_cnt4), 32'(vecs[i].e_c0));
         check($sformatf("v%0d_out1_cnt4", i), 32'(out1_cnt4), 32'(vecs[i].e_c1));
      end

      // Throughput: 100 alternating beats, one per cycle, no gaps.
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, i[0], 32'h1000 + 32'(i), 1'b1, 1'b1, 1'b0);
         #1;
         check("tp_in_prdy", 32'(in_prdy), 32'h1);
         tick();
         if (i[0] == 1'b0) begin
            check("tp_out0_pvld", 32'(out0_pvld), 32'h1);
            check("tp_out0_pd",   out0_pd,        32'h1000 + 32'(i));
            check("tp_out1_pvld", 32'(out1_pvld), 32'h0);
         end else begin
            check("tp_out1_pvld", 32'(out1_pvld), 32'h1);
            check("tp_out1_pd",   out1_pd,        32'h1000 + 32'(i));
            check("tp_out0_pvld", 32'(out0_pvld), 32'h0);
         end
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      check("tp_out0_cnt", 32'(out0_cnt), 32'd50);
      check("tp_out1_cnt", 32'(out1_cnt), 32'd50);
      check("tp_drained",  32'({out0_pvld, out1_pvld}), 32'h0);

      // Saturation: 20 out1 transfers on a 4-bit counter.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      tick();
      check("sat_clr_cnt4", 32'(out1_cnt4), 32'h0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 32'h200 + 32'(i), 1'b1, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      tick();
      check("sat_out1_cnt4", 32'(out1_cnt4), 32'd15);
      check("sat_out1_cnt",  32'(out1_cnt),  32'd20);

      // Clear coincident with a transfer wins.
      drive(1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      #1;
      check("clr_xfer_pvld", 32'(out1_pvld4), 32'h1);
      tick();
      check("clr_out1_cnt4", 32'(out1_cnt4), 32'h0);
      check("clr_out1_cnt",  32'(out1_cnt),  32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

      // Mid-run reset: nonzero counters, both FIFOs full.
      drive(1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 32'hD1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 32'hE0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 32'hE1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 32'hD2, 1'b0, 1'b0, 1'b0);
      #1;
      check("full_in_prdy_sel0", 32'(in_prdy), 32'h0);
      in_sel = 1'b1;
      #1;
      check("full_in_prdy_sel1", 32'(in_prdy), 32'h0);
      check("pre_rst_cnts", 32'({out0_cnt, out1_cnt}), 32'h0001_0001);
      check("pre_rst_pds",  {out0_pd[15:0], out1_pd[15:0]}, 32'h00D0_00E0);
      in_pvld = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("arst_pvld",    32'({out0_pvld, out1_pvld}), 32'h0);
      check("arst_out0_cnt", 32'(out0_cnt), 32'h0);
      check("arst_out1_cnt", 32'(out1_cnt), 32'h0);
      check("arst_in_prdy", 32'(in_prdy), 32'h1);
      #2;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_no_stale", 32'({out0_pvld, out1_pvld}), 32'h0);
      end
      drive(1'b1, 1'b0, 32'h77, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      check("post_rst_pvld", 32'(out0_pvld), 32'h1);
      check("post_rst_pd",   out0_pd,        32'h77);
      check("post_rst_cnt",  32'(out0_cnt),  32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_demux2.md
PIPE_DEMUX2 -- requirements
Module: pipe_demux2

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, payload width in bits (legal 1..256).
REQ-002 The block SHALL provide parameter CNT_W, default 16, width of per-output transfer counters.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 nvdla_core_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 nvdla_core_rstn  input  1  asynchronous active-low reset.
REQ-006 in_pvld  input  1  upstream payload valid.
REQ-007 in_prdy  output  1  upstream ready; transfer when in_pvld && in_prdy.
REQ-008 in_sel  input  1  route select, qualified by in_pvld: 0 -> out0, 1 -> out1.
REQ-009 in_pd  input  WIDTH  upstream payload.
REQ-010 out0_pvld / out1_pvld  output  1  output valid per port.
REQ-011 out0_prdy / out1_prdy  input  1  downstream ready per port.
REQ-012 out0_pd / out1_pd  output  WIDTH  output payload per port.
REQ-013 cnt_clr  input  1  synchronous clear of both transfer counters.
REQ-014 out0_cnt / out1_cnt  output  CNT_W  saturating count of completed output transfers.

Function
REQ-015 Each output port SHALL own an independent 2-entry FIFO (skid buffer); the block is the 1-to-2 counterpart of a 2:1 select.
REQ-016 in_prdy SHALL equal "selected FIFO not full", derived from registered occupancy and in_sel only; it SHALL NOT depend combinationally on out0_prdy/out1_prdy.
REQ-017 An accepted beat SHALL be written only to the FIFO chosen by in_sel in the accept cycle; the other FIFO SHALL be unchanged.
REQ-018 outN_pvld SHALL be 1 whenever FIFO N occupancy > 0; outN_pd SHALL present its oldest entry, driven from registers.
REQ-019 Minimum latency SHALL be 1 cycle: a beat accepted at edge k is visible on outN_pvld/outN_pd after edge k.
REQ-020 Per-port order SHALL be preserved; no ordering is guaranteed between out0 and out1.
REQ-021 Per-FIFO occupancy states: EMPTY(0), HALF(1), FULL(2); push-only increments, pop-only decrements, push and pop in the same cycle keeps occupancy.
REQ-022 Push into a FULL FIFO SHALL be impossible because in_prdy=0; a simultaneous pop does not raise in_prdy in the same cycle.
REQ-023 Both FIFOs SHALL push/pop independently in the same cycle without interaction; sustained throughput of 1 beat/cycle per port SHALL be met while that port's outN_prdy=1.
REQ-024 Read/write pointers SHALL be 1 bit per FIFO and wrap 1 -> 0.
REQ-025 outN_cnt SHALL increment by 1 on each outN_pvld && outN_prdy cycle and saturate at 2^CNT_W-1.
REQ-026 cnt_clr=1 SHALL load 0 into both counters, overriding a same-cycle increment.
REQ-027 in_pd and in_sel SHALL be ignored when in_pvld=0; payload registers need no reset.

Reset
REQ-028 On nvdla_core_rstn=0, both FIFOs SHALL become EMPTY, pointers 0, counters 0, immediately and without a clock.
REQ-029 During and after reset: in_prdy=1, out0_pvld=0, out1_pvld=0, out0_cnt=0, out1_cnt=0; outN_pd are don't-care.
REQ-030 Reset asserted mid-operation SHALL discard all buffered beats; no beat buffered before reset SHALL appear after reset.

Verification
REQ-031 Route: send 0xA5A5A5A5 sel=0, then 0x5A5A5A5A sel=1, both outN_prdy=1 -> out0 shows 0xA5A5A5A5 one cycle after accept, out1 shows 0x5A5A5A5A one cycle after its accept, counts 1/1.
REQ-032 Backpressure: out0_prdy=0, stream sel=0 beats 1,2,3 -> beats 1,2 accepted, in_prdy=0 on beat 3 until out0_prdy=1, then out0 delivers 1,2,3 in order, out0_cnt=3.
REQ-033 Independence: out0 FULL with out0_prdy=0, present a sel=1 beat -> in_prdy=1 and the beat appears on out1; out0 contents unchanged.
REQ-034 Throughput: 100 beats alternating sel, both prdy=1 -> 1 beat accepted per cycle, counts 50/50, no gaps.
REQ-035 Saturation/clear: CNT_W=4, 20 out1 transfers -> out1_cnt=15; cnt_clr coincident with a transfer -> out1_cnt=0 next cycle.
REQ-036 Reset mid-run: both FIFOs FULL, pulse nvdla_core_rstn low asynchronously -> pvld outputs 0 and counts 0 immediately, in_prdy=1, no stale beats afterwards.
